// File: rtl/onehot_seq_decoder.sv
// onehot_seq_decoder
// Registered binary-to-one-hot decoder with a built-in sequencer. It decodes
// an index onto a one-hot bus and can also sweep that bus by itself. The sweep
// runs either continuously (SCAN) or once from a start index (ONESHOT). Each
// position is held for dwell+1 enabled cycles.
//
// Parameters:
//   SEL_W    index width; the one-hot bus is OUT_W = 2**SEL_W bits wide
//   DWELL_W  width of the dwell-count input
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; takes priority over en
//   en       clock enable; 0 freezes all state and forces wrap low
//   mode     00 OFF, 01 DECODE, 10 SCAN, 11 ONESHOT
//   in       index to decode (DECODE) or start index (ONESHOT)
//   in_valid qualifies in while in DECODE
//   dwell    each sweep position is held for dwell+1 enabled cycles
//   y        registered one-hot output, or all zeros
//   idx      registered current index
//   wrap     one-cycle pulse on a SCAN wrap or on ONESHOT completion
//   busy     high while a sweep is in progress
module onehot_seq_decoder #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [1:0]              mode,
   input  logic [SEL_W-1:0]        in,
   input  logic                    in_valid,
   input  logic [DWELL_W-1:0]      dwell,
   output logic [(2**SEL_W)-1:0]   y,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap,
   output logic                    busy
);

   localparam int OUT_W = 2**SEL_W;

   localparam logic [OUT_W-1:0]   Y_ONE     = OUT_W'(1'b1);
   localparam logic [OUT_W-1:0]   Y_ZERO    = {OUT_W{1'b0}};
   localparam logic [SEL_W-1:0]   IDX_ONE   = SEL_W'(1'b1);
   localparam logic [SEL_W-1:0]   IDX_LAST  = {SEL_W{1'b1}};
   localparam logic [DWELL_W-1:0] CNT_ONE   = DWELL_W'(1'b1);
   localparam logic [DWELL_W-1:0] CNT_ZERO  = {DWELL_W{1'b0}};

   // The state encoding matches the mode encoding, so the requested mode
   // casts directly onto the next state.
   typedef enum logic [1:0] {
      ST_OFF     = 2'b00,
      ST_DECODE  = 2'b01,
      ST_SCAN    = 2'b10,
      ST_ONESHOT = 2'b11
   } state_t;

   state_t               state_r,     state_nxt;
   logic [OUT_W-1:0]     y_r,         y_nxt;
   logic [SEL_W-1:0]     idx_r,       idx_nxt;
   logic [DWELL_W-1:0]   dwell_cnt_r, dwell_cnt_nxt;
   logic                 wrap_r,      wrap_nxt;
   logic                 busy_r,      busy_nxt;
   logic                 done_r,      done_nxt;

   state_t               mode_s;
   logic                 entry_s;
   logic                 adv_s;
   logic                 last_s;
   logic [SEL_W-1:0]     idx_inc_s;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
      onehot = Y_ONE << i;
   endfunction

   assign mode_s    = state_t'(mode);
   assign entry_s   = (mode_s != state_r);
   // dwell is compared live, so lowering it mid-dwell advances at once.
   assign adv_s     = (dwell_cnt_r >= dwell);
   assign last_s    = (idx_r == IDX_LAST);
   assign idx_inc_s = idx_r + IDX_ONE;

   // Next-state and next-output logic for the mode FSM and the sweep counter
   always_comb begin
      state_nxt     = state_r;
      y_nxt         = y_r;
      idx_nxt       = idx_r;
      dwell_cnt_nxt = dwell_cnt_r;
      busy_nxt      = busy_r;
      done_nxt      = done_r;
      wrap_nxt      = 1'b0;

      if (en) begin
         state_nxt = mode_s;
         if (entry_s) begin
            dwell_cnt_nxt = CNT_ZERO;
            done_nxt      = 1'b0;
         end else begin
            dwell_cnt_nxt = dwell_cnt_r;
            done_nxt      = done_r;
         end

         case (mode_s)
            ST_OFF: begin
               y_nxt    = Y_ZERO;
               busy_nxt = 1'b0;
            end
            ST_DECODE: begin
               busy_nxt = 1'b0;
               if (in_valid) begin
                  idx_nxt = in;
                  y_nxt   = onehot(in);
               end else if (entry_s) begin
                  // Coming from OFF or from a finished ONESHOT, y may be zero.
                  // Show the retained index again.
                  y_nxt = onehot(idx_r);
               end else begin
                  y_nxt = y_r;
               end
            end
            ST_SCAN: begin
               busy_nxt = 1'b1;
               if (entry_s) begin
                  // An entry edge never advances, even if the dwell has expired.
                  y_nxt = onehot(idx_r);
               end else if (adv_s) begin
                  dwell_cnt_nxt = CNT_ZERO;
                  idx_nxt       = idx_inc_s;
                  y_nxt         = onehot(idx_inc_s);
                  wrap_nxt      = last_s;
               end else begin
                  dwell_cnt_nxt = dwell_cnt_r + CNT_ONE;
               end
            end
            ST_ONESHOT: begin
               if (entry_s) begin
                  idx_nxt  = in;
                  y_nxt    = onehot(in);
                  busy_nxt = 1'b1;
               end else if (done_r) begin
                  // The sweep is finished. Hold until mode changes.
                  busy_nxt = 1'b0;
               end else if (adv_s) begin
                  dwell_cnt_nxt = CNT_ZERO;
                  if (last_s) begin
                     // Completion: blank the bus and park idx on the last position.
                     y_nxt    = Y_ZERO;
                     busy_nxt = 1'b0;
                     wrap_nxt = 1'b1;
                     done_nxt = 1'b1;
                  end else begin
                     idx_nxt  = idx_inc_s;
                     y_nxt    = onehot(idx_inc_s);
                     busy_nxt = 1'b1;
                  end
               end else begin
                  dwell_cnt_nxt = dwell_cnt_r + CNT_ONE;
                  busy_nxt      = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_OFF;
               y_nxt     = Y_ZERO;
               busy_nxt  = 1'b0;
            end
         endcase
      end else begin
         // Frozen: hold every register. wrap stays low so a pulse cannot stretch.
         wrap_nxt = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_OFF;
         y_r         <= Y_ZERO;
         idx_r       <= {SEL_W{1'b0}};
         dwell_cnt_r <= CNT_ZERO;
         wrap_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         y_r         <= y_nxt;
         idx_r       <= idx_nxt;
         dwell_cnt_r <= dwell_cnt_nxt;
         wrap_r      <= wrap_nxt;
         busy_r      <= busy_nxt;
         done_r      <= done_nxt;
      end
   end

   assign y    = y_r;
   assign idx  = idx_r;
   assign wrap = wrap_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Testbench for onehot_seq_decoder: table-driven directed vectors on a
// SEL_W=3 instance. A hand-written SCAN sweep covers SEL_W=1,2,4 instances.
module tb_onehot_seq_decoder;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [2:0] sel_in;
   logic       in_valid;
   logic [3:0] dwell;

   logic [7:0] y;
   logic [2:0] idx;
   logic       wrap;
   logic       busy;

   logic [0:0]  in1;
   logic [1:0]  in2;
   logic [3:0]  in4;
   logic [1:0]  y1;
   logic [3:0]  y2;
   logic [15:0] y4;
   logic [0:0]  idx1;
   logic [1:0]  idx2;
   logic [3:0]  idx4;
   logic        wrap1, wrap2, wrap4;
   logic        busy1, busy2, busy4;

   int total;
   int bad;

   onehot_seq_decoder #(.SEL_W(3), .DWELL_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(sel_in),
      .in_valid(in_valid), .dwell(dwell),
      .y(y), .idx(idx), .wrap(wrap), .busy(busy)
   );

   onehot_seq_decoder #(.SEL_W(1), .DWELL_W(4)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in1),
      .in_valid(in_valid), .dwell(dwell),
      .y(y1), .idx(idx1), .wrap(wrap1), .busy(busy1)
   );

   onehot_seq_decoder #(.SEL_W(2), .DWELL_W(4)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in2),
      .in_valid(in_valid), .dwell(dwell),
      .y(y2), .idx(idx2), .wrap(wrap2), .busy(busy2)
   );

   onehot_seq_decoder #(.SEL_W(4), .DWELL_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in4),
      .in_valid(in_valid), .dwell(dwell),
      .y(y4), .idx(idx4), .wrap(wrap4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [2:0] sel;
      logic       iv;
      logic [3:0] dwell;
      logic [7:0] y;
      logic [2:0] idx;
      logic       wrap;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic r, input logic e, input logic [1:0] m,
                       input logic [2:0] s, input logic v, input logic [3:0] d,
                       input logic [7:0] ey, input logic [2:0] ei,
                       input logic ew, input logic eb);
      vec_t t;
      t.rst = r; t.en = e; t.mode = m; t.sel = s; t.iv = v; t.dwell = d;
      t.y = ey; t.idx = ei; t.wrap = ew; t.busy = eb;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int m1, m2, m4;
      int wc1, wc2, wc4;
      logic ew;

      total = 0;
      bad   = 0;
      rst = 1'b1; en = 1'b1; mode = 2'b00; sel_in = 3'd0; in_valid = 1'b0;
      dwell = 4'd0; in1 = 1'b0; in2 = 2'd0; in4 = 4'd0;

      //     rst   en    mode   in    iv    dw     y        idx   wrap  busy
      addv(1'b1, 1'b1, 2'b00, 3'd0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0); // 0 reset
      addv(1'b1, 1'b0, 2'b00, 3'd0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0); // 1 rst over en
      addv(1'b0, 1'b1, 2'b01, 3'd5, 1'b1, 4'd0, 8'h20, 3'd5, 1'b0, 1'b0); // 2 decode 5
      addv(1'b0, 1'b1, 2'b01, 3'd2, 1'b0, 4'd0, 8'h20, 3'd5, 1'b0, 1'b0); // 3 invalid holds
      addv(1'b0, 1'b1, 2'b01, 3'd3, 1'b1, 4'd0, 8'h08, 3'd3, 1'b0, 1'b0); // 4
      addv(1'b0, 1'b1, 2'b01, 3'd6, 1'b1, 4'd0, 8'h40, 3'd6, 1'b0, 1'b0); // 5
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b1); // 6 scan entry
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b1); // 7
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h40, 3'd6, 1'b0, 1'b1); // 8
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b1); // 9
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b1); // 10
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h80, 3'd7, 1'b0, 1'b1); // 11
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b1, 1'b1); // 12 wrap
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 13 cnt=1
      addv(1'b0, 1'b0, 2'b10, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 14 frozen
      addv(1'b0, 1'b0, 2'b10, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 15
      addv(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 16 mode unseen
      addv(1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 17
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h01, 3'd0, 1'b0, 1'b1); // 18 cnt=2
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h02, 3'd1, 1'b0, 1'b1); // 19 resumes
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd2, 8'h02, 3'd1, 1'b0, 1'b1); // 20 cnt=1
      addv(1'b0, 1'b1, 2'b10, 3'd0, 1'b0, 4'd0, 8'h04, 3'd2, 1'b0, 1'b1); // 21 dwell cut
      addv(1'b0, 1'b1, 2'b11, 3'd5, 1'b0, 4'd0, 8'h20, 3'd5, 1'b0, 1'b1); // 22 oneshot entry
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h40, 3'd6, 1'b0, 1'b1); // 23
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h80, 3'd7, 1'b0, 1'b1); // 24
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h00, 3'd7, 1'b1, 1'b0); // 25 complete
      addv(1'b0, 1'b0, 2'b11, 3'd0, 1'b0, 4'd0, 8'h00, 3'd7, 1'b0, 1'b0); // 26 no stretch
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h00, 3'd7, 1'b0, 1'b0); // 27 held
      addv(1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 4'd0, 8'h00, 3'd7, 1'b0, 1'b0); // 28 off
      addv(1'b0, 1'b1, 2'b11, 3'd1, 1'b0, 4'd0, 8'h02, 3'd1, 1'b0, 1'b1); // 29 re-arm
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h04, 3'd2, 1'b0, 1'b1); // 30
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h08, 3'd3, 1'b0, 1'b1); // 31 idx=3
      addv(1'b1, 1'b1, 2'b11, 3'd0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0); // 32 rst abort
      addv(1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 4'd0, 8'h00, 3'd0, 1'b0, 1'b0); // 33 stays off
      addv(1'b0, 1'b1, 2'b11, 3'd4, 1'b0, 4'd1, 8'h10, 3'd4, 1'b0, 1'b1); // 34
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd1, 8'h10, 3'd4, 1'b0, 1'b1); // 35
      addv(1'b0, 1'b1, 2'b11, 3'd0, 1'b0, 4'd1, 8'h20, 3'd5, 1'b0, 1'b1); // 36
      addv(1'b0, 1'b1, 2'b01, 3'd2, 1'b0, 4'd0, 8'h20, 3'd5, 1'b0, 1'b0); // 37 decode entry iv=0
      addv(1'b0, 1'b1, 2'b01, 3'd0, 1'b1, 4'd0, 8'h01, 3'd0, 1'b0, 1'b0); // 38

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
         sel_in = vecs[i].sel; in_valid = vecs[i].iv; dwell = vecs[i].dwell;
         step();
         chk($sformatf("row%0d y", i),    32'(y),    32'(vecs[i].y));
         chk($sformatf("row%0d idx", i),  32'(idx),  32'(vecs[i].idx));
         chk($sformatf("row%0d wrap", i), 32'(wrap), 32'(vecs[i].wrap));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      end

      // Parameter sweep: SCAN with dwell=0 on SEL_W=1,2,4.
      rst = 1'b1; en = 1'b1; mode = 2'b00; dwell = 4'd0; in_valid = 1'b0;
      step();
      rst = 1'b0; mode = 2'b10;
      step();
      m1 = 0; m2 = 0; m4 = 0;
      wc1 = 0; wc2 = 0; wc4 = 0;
      chk("sweep1 entry y", 32'(y1), 32'd1);
      chk("sweep2 entry y", 32'(y2), 32'd1);
      chk("sweep4 entry y", 32'(y4), 32'd1);
      for (int c = 0; c < 32; c++) begin
         step();
         ew = (m1 == 1);  m1 = (m1 + 1) % 2;
         chk($sformatf("sweep1 c%0d y", c),    32'(y1),    32'd1 << m1);
         chk($sformatf("sweep1 c%0d wrap", c), 32'(wrap1), 32'(ew));
         ew = (m2 == 3);  m2 = (m2 + 1) % 4;
         chk($sformatf("sweep2 c%0d y", c),    32'(y2),    32'd1 << m2);
         chk($sformatf("sweep2 c%0d wrap", c), 32'(wrap2), 32'(ew));
         ew = (m4 == 15); m4 = (m4 + 1) % 16;
         chk($sformatf("sweep4 c%0d y", c),    32'(y4),    32'd1 << m4);
         chk($sformatf("sweep4 c%0d wrap", c), 32'(wrap4), 32'(ew));
         wc1 += int'(wrap1);
         wc2 += int'(wrap2);
         wc4 += int'(wrap4);
      end
      chk("sweep1 wraps", 32'(wc1), 32'd16);
      chk("sweep2 wraps", 32'(wc2), 32'd8);
      chk("sweep4 wraps", 32'(wc4), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/onehot_seq_decoder.md
# onehot_seq_decoder

Parametrised, registered binary-to-one-hot decoder with built-in sequencing. It decodes a SEL_W-bit index onto a 2^SEL_W-bit one-hot bus and can also sweep that bus autonomously, either continuously or once. The programmable dwell per position lets it drive row/column strobes, LED or segment multiplexing, and chip-select scanning from one block.

## Interface
Parameters:
- SEL_W, 3, index width; OUT_W = 2**SEL_W is a derived localparam.
- DWELL_W, 4, width of the dwell-count input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; 0 freezes all state, and wrap is forced to 0.
- mode  in  2  00 OFF, 01 DECODE, 10 SCAN, 11 ONESHOT.
- in  in  SEL_W  index to decode (DECODE) or start index (ONESHOT).
- in_valid  in  1  qualifies `in` in DECODE mode.
- dwell  in  DWELL_W  each position is held for dwell+1 cycles in SCAN/ONESHOT.
- y  out  OUT_W  registered one-hot output, or all zeros.
- idx  out  SEL_W  registered current index.
- wrap  out  1  one-cycle pulse on SCAN wrap or ONESHOT completion.
- busy  out  1  high while sweeping (SCAN, or ONESHOT not yet complete).

## Operation
- Reset (rst=1 at an edge, overrides en): state=OFF, y=0, idx=0, dwell_cnt=0, wrap=0, busy=0, done=0.
- States: OFF, DECODE, SCAN, ONESHOT. The state follows `mode` at every enabled edge.
- Entry means an edge where `mode` differs from the current state. On entry: dwell_cnt<=0 and done<=0.
- OFF: y<=0, busy<=0. idx is retained.
- DECODE, on entry or while in state:
  - in_valid=1: idx<=in, y<=1<<in.
  - in_valid=0: hold idx and y. On entry with in_valid=0: y<=1<<idx.
  - busy<=0.
- SCAN:
  - On entry: y<=1<<idx, busy<=1.
  - Each later enabled edge: if dwell_cnt>=dwell, then dwell_cnt<=0, idx<=idx+1 (modulo OUT_W), y<=1<<(idx+1), and wrap<=1 when old idx==OUT_W-1.
  - Otherwise dwell_cnt<=dwell_cnt+1.
- ONESHOT:
  - On entry: idx<=in, y<=1<<in, busy<=1.
  - Advances exactly like SCAN.
  - Completion: when dwell expires with idx==OUT_W-1, y<=0, busy<=0, wrap<=1, done<=1, and idx stays at OUT_W-1.
  - With done=1 the block holds everything until mode changes. Re-arm by leaving ONESHOT and re-entering.
- dwell is compared live using >=. Reducing it mid-dwell causes an advance at the next edge. dwell=0 advances every cycle.
- wrap defaults to 0 on every edge unless set by the rules above.
- Invariant: y is either all zeros or exactly one-hot with y[idx]=1.

## Timing
- All outputs are registered. Input-to-output latency is 1 cycle, e.g. in_valid sampled at edge N gives y at edge N.
- A mode change sampled at edge N takes effect at edge N. There are no combinational paths from inputs to outputs.
- en=0:
  - All registers hold, including dwell_cnt and state.
  - wrap<=0, so a pulse never stretches.
  - A mode change while en=0 is not seen until en returns.
- rst asserted mid-sweep aborts the sweep on that edge with the full reset values. The sweep resumes in OFF.
- Simultaneous events:
  - rst has priority over en.
  - An entry edge does not advance the index, even if dwell_cnt>=dwell.
  - In DECODE, in_valid on the entry edge is honoured.

## Test plan
- Reset then DECODE, SEL_W=3: in=5 with in_valid=1 -> y=8'b0010_0000, idx=5 after 1 edge. Then in_valid=0, in=2 -> y is unchanged.
- SCAN, dwell=2, starting idx=6:
  - y=0x40 for 3 cycles, then y=0x80 for 3 cycles, then y=0x01.
  - wrap is high only on the edge where y becomes 0x01.
- ONESHOT, in=5, dwell=0 -> y=0x20, 0x40, 0x80, then 0x00, with wrap=1 for one cycle, busy falling with y=0x00, and idx=7. Holding mode=11 afterwards keeps y=0.
- en low for 4 cycles mid-dwell in SCAN -> y, idx, and the dwell phase are frozen, and the sweep resumes with the remaining dwell intact.
- rst pulsed mid-ONESHOT at idx=3 -> next edge gives y=0, idx=0, busy=0, wrap=0. Outputs stay in OFF until mode is re-applied.
- Parameter sweep SEL_W=1,2,4 in SCAN with dwell=0 -> y cycles through all OUT_W one-hot values, with exactly one wrap per OUT_W cycles.
